// File: rtl/csr_timer_if.sv
// CSR access bus between the WB-stage CSR unit (master) and the timer block (slave).
// Carries one write port (already write-masked) and one combinational read port.
interface csr_timer_if;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;

  modport master (
    output csr_we,
    output csr_waddr,
    output csr_wdata,
    output csr_raddr,
    input  csr_rdata
  );

  modport slave (
    input  csr_we,
    input  csr_waddr,
    input  csr_wdata,
    input  csr_raddr,
    output csr_rdata
  );
endinterface

// File: rtl/csr_timer.sv
// Constant-timer CSR block (TID/TCFG/TVAL/TICLR), its interrupt, and an optional
// 64-bit stable counter built only when STABLE_COUNTER_EN is defined.
module csr_timer #(
  parameter int unsigned TIMESIZE = 12
) (
  input  logic             aclk,
  input  logic             reset,
  csr_timer_if.slave       csr,
  output logic             timer_int,
  output logic [31:0]      cnt_lo,
  output logic [31:0]      cnt_hi
);

  localparam int unsigned CFGW = TIMESIZE + 2;

  localparam logic [13:0] CSR_TID   = 14'h040;
  localparam logic [13:0] CSR_TCFG  = 14'h041;
  localparam logic [13:0] CSR_TVAL  = 14'h042;
  localparam logic [13:0] CSR_TICLR = 14'h044;

  localparam logic [TIMESIZE-1:0] TVAL_ZERO = {TIMESIZE{1'b0}};
  localparam logic [TIMESIZE-1:0] TVAL_ONE  = TIMESIZE'(1);
  localparam logic [TIMESIZE-1:0] TVAL_ALL1 = {TIMESIZE{1'b1}};

  logic [CFGW-1:0]     tcfg_q,  tcfg_d;
  logic [TIMESIZE-1:0] tval_q,  tval_d;
  logic                armed_q, armed_d;
  logic                tint_q,  tint_d;
  logic [31:0]         tid_q,   tid_d;

  logic                tcfg_wr_s;
  logic                ticlr_wr_s;
  logic                tid_wr_s;
  logic                cfg_en_s;
  logic                cfg_periodic_s;
  logic [TIMESIZE-1:0] cfg_init_s;
  logic                count_s;
  logic                expire_s;
  logic                halt_s;
  logic [31:0]         rdata_s;

  assign tcfg_wr_s  = csr.csr_we && (csr.csr_waddr == CSR_TCFG);
  assign ticlr_wr_s = csr.csr_we && (csr.csr_waddr == CSR_TICLR);
  assign tid_wr_s   = csr.csr_we && (csr.csr_waddr == CSR_TID);

  assign cfg_en_s       = tcfg_q[0];
  assign cfg_periodic_s = tcfg_q[1];
  assign cfg_init_s     = tcfg_q[CFGW-1:2];

  // A running timer either decrements (nonzero) or sits in its one-cycle expired state (zero).
  assign count_s  = armed_q && cfg_en_s && (tval_q != TVAL_ZERO);
  assign expire_s = count_s && (tval_q == TVAL_ONE);
  assign halt_s   = armed_q && cfg_en_s && (tval_q == TVAL_ZERO);

  // Next-state for the timer configuration, count and arming.
  always_comb begin
    tcfg_d  = tcfg_q;
    tval_d  = tval_q;
    armed_d = armed_q;
    if (tcfg_wr_s) begin
      tcfg_d  = csr.csr_wdata[CFGW-1:0];
      tval_d  = csr.csr_wdata[CFGW-1:2];
      armed_d = csr.csr_wdata[0];
    end else if (count_s) begin
      tval_d = tval_q - TVAL_ONE;
    end else if (halt_s) begin
      if (cfg_periodic_s) begin
        tval_d = cfg_init_s;
      end else begin
        tval_d  = TVAL_ALL1;
        armed_d = 1'b0;
      end
    end else begin
      tval_d = tval_q;
    end
  end

  // Interrupt pending: expiry beats a same-edge clear; a TCFG write suppresses expiry.
  always_comb begin
    tint_d = tint_q;
    if (expire_s && !tcfg_wr_s) begin
      tint_d = 1'b1;
    end else if (ticlr_wr_s && csr.csr_wdata[0]) begin
      tint_d = 1'b0;
    end else begin
      tint_d = tint_q;
    end
  end

  // Next-state for the software ID register.
  always_comb begin
    tid_d = tid_q;
    if (tid_wr_s) begin
      tid_d = csr.csr_wdata;
    end else begin
      tid_d = tid_q;
    end
  end

  // Timer state registers.
  always_ff @(posedge aclk) begin
    if (reset) begin
      tcfg_q  <= {CFGW{1'b0}};
      tval_q  <= TVAL_ALL1;
      armed_q <= 1'b0;
      tint_q  <= 1'b0;
      tid_q   <= 32'h0000_0000;
    end else begin
      tcfg_q  <= tcfg_d;
      tval_q  <= tval_d;
      armed_q <= armed_d;
      tint_q  <= tint_d;
      tid_q   <= tid_d;
    end
  end

  // Read mux reflects pre-edge state only; unknown numbers read zero.
  always_comb begin
    rdata_s = 32'h0000_0000;
    case (csr.csr_raddr)
      CSR_TID:   rdata_s = tid_q;
      CSR_TCFG:  rdata_s = 32'(tcfg_q);
      CSR_TVAL:  rdata_s = 32'(tval_q);
      CSR_TICLR: rdata_s = 32'h0000_0000;
      default:   rdata_s = 32'h0000_0000;
    endcase
  end

  assign csr.csr_rdata = rdata_s;
  assign timer_int     = tint_q;

`ifdef STABLE_COUNTER_EN
  logic [63:0] stable_cnt_q, stable_cnt_d;

  assign stable_cnt_d = stable_cnt_q + 64'd1;

  // Free-running 64-bit counter, wraps naturally.
  always_ff @(posedge aclk) begin
    if (reset) begin
      stable_cnt_q <= 64'd0;
    end else begin
      stable_cnt_q <= stable_cnt_d;
    end
  end

  assign cnt_lo = stable_cnt_q[31:0];
  assign cnt_hi = stable_cnt_q[63:32];
`else
  assign cnt_lo = 32'h0000_0000;
  assign cnt_hi = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_csr_timer.sv
// Directed self-checking bench for csr_timer (TIMESIZE=12); expectations hand-computed.
module tb_csr_timer;

  localparam logic [13:0] A_TID   = 14'h040;
  localparam logic [13:0] A_TCFG  = 14'h041;
  localparam logic [13:0] A_TVAL  = 14'h042;
  localparam logic [13:0] A_TICLR = 14'h044;

  logic        aclk;
  logic        reset;
  logic        timer_int;
  logic [31:0] cnt_lo;
  logic [31:0] cnt_hi;
  int          n_checks;
  int          n_errors;

  csr_timer_if csr_bus ();

  csr_timer #(.TIMESIZE(12)) dut (
    .aclk      (aclk),
    .reset     (reset),
    .csr       (csr_bus),
    .timer_int (timer_int),
    .cnt_lo    (cnt_lo),
    .cnt_hi    (cnt_hi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic [31:0] seq_oneshot [6] = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'h0000_0FFF};
  logic [31:0] seq_periodic [7] = '{32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic rd_chk(input string tag, input logic [13:0] addr, input logic [31:0] exp);
    csr_bus.csr_raddr = addr;
    #1;
    check_eq(tag, csr_bus.csr_rdata, exp);
  endtask

  task automatic wr(input logic [13:0] addr, input logic [31:0] data);
    csr_bus.csr_we    = 1'b1;
    csr_bus.csr_waddr = addr;
    csr_bus.csr_wdata = data;
    tick();
    csr_bus.csr_we    = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    csr_bus.csr_we    = 1'b0;
    csr_bus.csr_waddr = 14'h000;
    csr_bus.csr_wdata = 32'h0000_0000;
    csr_bus.csr_raddr = 14'h000;
    repeat (3) tick();

    rd_chk("rst_tcfg", A_TCFG, 32'h0000_0000);
    rd_chk("rst_tval", A_TVAL, 32'h0000_0FFF);
    rd_chk("rst_tid", A_TID, 32'h0000_0000);
    rd_chk("rst_ticlr", A_TICLR, 32'h0000_0000);
    check_eq("rst_int", {31'd0, timer_int}, 32'd0);
    check_eq("rst_cnt_lo", cnt_lo, 32'd0);
    check_eq("rst_cnt_hi", cnt_hi, 32'd0);

    reset = 1'b0;
    repeat (10) tick();
`ifdef STABLE_COUNTER_EN
    check_eq("cnt_lo_10", cnt_lo, 32'd10);
`else
    check_eq("cnt_lo_10", cnt_lo, 32'd0);
`endif
    check_eq("cnt_hi_10", cnt_hi, 32'd0);

    // One-shot: InitVal=5
    wr(A_TCFG, 32'h0000_0015);
    rd_chk("os_load", A_TVAL, 32'd5);
    check_eq("os_int_lo", {31'd0, timer_int}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      rd_chk($sformatf("os_tval%0d", i), A_TVAL, seq_oneshot[i]);
      if (i == 4) check_eq("os_int_exp", {31'd0, timer_int}, 32'd1);
    end
    repeat (2) tick();
    rd_chk("os_hold", A_TVAL, 32'h0000_0FFF);
    rd_chk("os_tcfg", A_TCFG, 32'h0000_0015);
    check_eq("os_int_keep", {31'd0, timer_int}, 32'd1);
    wr(A_TICLR, 32'h0000_0001);
    check_eq("clr_int", {31'd0, timer_int}, 32'd0);

    // Periodic: InitVal=3
    wr(A_TCFG, 32'h0000_000F);
    rd_chk("per_load", A_TVAL, 32'd3);
    for (int i = 0; i < 7; i++) begin
      tick();
      rd_chk($sformatf("per_tval%0d", i), A_TVAL, seq_periodic[i]);
      if (i == 1) check_eq("per_int_pre", {31'd0, timer_int}, 32'd0);
      if (i == 2) check_eq("per_int_exp", {31'd0, timer_int}, 32'd1);
    end
    wr(A_TICLR, 32'h0000_0001);
    rd_chk("per_reload", A_TVAL, 32'd3);
    check_eq("per_clr", {31'd0, timer_int}, 32'd0);
    tick();
    tick();
    rd_chk("per_at1", A_TVAL, 32'd1);
    wr(A_TICLR, 32'h0000_0001);
    check_eq("clr_vs_exp", {31'd0, timer_int}, 32'd1);
    wr(A_TICLR, 32'h0000_0002);
    check_eq("clr_bit1", {31'd0, timer_int}, 32'd1);
    rd_chk("per_reload2", A_TVAL, 32'd3);

    // TCFG write beats decrement and expiry
    wr(A_TICLR, 32'h0000_0001);
    rd_chk("mid_at2", A_TVAL, 32'd2);
    wr(A_TCFG, 32'h0000_0029);
    rd_chk("mid_load", A_TVAL, 32'd10);
    check_eq("mid_noexp", {31'd0, timer_int}, 32'd0);
    repeat (9) tick();
    rd_chk("pri_at1", A_TVAL, 32'd1);
    wr(A_TCFG, 32'h0000_0029);
    rd_chk("pri_load", A_TVAL, 32'd10);
    check_eq("pri_noexp", {31'd0, timer_int}, 32'd0);

    // Clearing En freezes the count, keeps pending interrupt
    repeat (10) tick();
    check_eq("en_exp", {31'd0, timer_int}, 32'd1);
    wr(A_TCFG, 32'h0000_0028);
    repeat (2) tick();
    rd_chk("en_frozen", A_TVAL, 32'd10);
    check_eq("en_int_kept", {31'd0, timer_int}, 32'd1);

    // Reset mid-count overrides a concurrent TCFG write
    wr(A_TCFG, 32'h0000_0029);
    repeat (2) tick();
    rd_chk("rc_at8", A_TVAL, 32'd8);
    reset = 1'b1;
    csr_bus.csr_we    = 1'b1;
    csr_bus.csr_waddr = A_TCFG;
    csr_bus.csr_wdata = 32'h0000_0015;
    tick();
    reset = 1'b0;
    csr_bus.csr_we = 1'b0;
    rd_chk("rc_tval", A_TVAL, 32'h0000_0FFF);
    rd_chk("rc_tcfg", A_TCFG, 32'h0000_0000);
    check_eq("rc_int", {31'd0, timer_int}, 32'd0);

    // Periodic with InitVal=0 stays at zero, never interrupts
    wr(A_TCFG, 32'h0000_0003);
    repeat (3) tick();
    rd_chk("z_tval", A_TVAL, 32'd0);
    check_eq("z_int", {31'd0, timer_int}, 32'd0);

    // TCFG upper bits read zero
    wr(A_TCFG, 32'hFFFF_FFFF);
    rd_chk("cfg_mask", A_TCFG, 32'h0000_3FFF);
    rd_chk("cfg_tval", A_TVAL, 32'h0000_0FFF);
    tick();
    rd_chk("cfg_dec", A_TVAL, 32'h0000_0FFE);

    // TID write, no bypass, other numbers read zero
    wr(A_TID, 32'h1234_5678);
    rd_chk("tid_rd", A_TID, 32'h1234_5678);
    rd_chk("ticlr_rd", A_TICLR, 32'h0000_0000);
    rd_chk("other_rd", 14'h100, 32'h0000_0000);
    csr_bus.csr_we    = 1'b1;
    csr_bus.csr_waddr = A_TID;
    csr_bus.csr_wdata = 32'hCAFE_F00D;
    rd_chk("tid_nobyp", A_TID, 32'h1234_5678);
    tick();
    csr_bus.csr_we = 1'b0;
    rd_chk("tid_new", A_TID, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_timer.md
CSR_TIMER -- requirements
Module: csr_timer

Interface
REQ-001 Parameter: TIMESIZE, default 12, timer value width in bits.
REQ-002 Port: aclk  in  1  core clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Port: csr_we  in  1  CSR write strobe from the WB-stage CSR unit.
REQ-005 Port: csr_waddr  in  14  CSR write number (TCFG=0x041, TICLR=0x044, TID=0x040).
REQ-006 Port: csr_wdata  in  32  write data, already masked with the CSR write mask.
REQ-007 Port: csr_raddr  in  14  CSR read number.
REQ-008 Port: csr_rdata  out  32  combinational read data for TID/TCFG/TVAL/TICLR; 0 for any other number.
REQ-009 Port: timer_int  out  1  timer interrupt pending, consumed as ESTAT.IS[11].
REQ-010 Port: cnt_lo  out  32  stable counter bits [31:0], for rdcntvl.
REQ-011 Port: cnt_hi  out  32  stable counter bits [63:32], for rdcntvh.

Function
REQ-012 TCFG SHALL hold TIMESIZE+2 bits: En=bit0, Periodic=bit1, InitVal=bits[TIMESIZE+1:2]; all upper bits read 0.
REQ-013 TVAL SHALL be a TIMESIZE-bit down-counter; upper bits read 0; software writes to TVAL are ignored.
REQ-014 A TCFG write SHALL update TCFG and load TVAL with the written InitVal on the same edge; armed is set to the written En.
REQ-015 While armed=1, TCFG.En=1 and TVAL!=0, TVAL SHALL decrement by 1 each cycle.
REQ-016 On the edge where TVAL goes 1->0 the timer SHALL expire.
- At expiry, timer_int is set on that same edge.
REQ-017 In the cycle where TVAL=0 and the timer is expired:
- if Periodic=1, the next edge reloads TVAL to InitVal and armed stays 1;
- if Periodic=0, the next edge sets TVAL to all-ones and clears armed.
- The timer then stays halted until the next TCFG write.
REQ-018 If TVAL=0 and Periodic=1 with InitVal=0, TVAL SHALL remain 0 and timer_int SHALL NOT be re-set.
REQ-019 A TICLR write with wdata[0]=1 SHALL clear timer_int on that edge.
- TICLR always reads 0.
- Other TICLR bits have no effect.
REQ-020 If expiry and a TICLR clear occur on the same edge, expiry SHALL win and timer_int ends at 1.
REQ-021 A TCFG write in the same cycle as a TVAL decrement or expiry SHALL take priority.
- TVAL=new InitVal.
- No expiry is signalled from the old count.
REQ-022 Clearing En via a TCFG write SHALL freeze decrement but SHALL NOT clear timer_int.
REQ-023 TID SHALL be a 32-bit read/write register; a write takes effect on the next edge.
REQ-024 csr_rdata SHALL reflect register state before the current edge; there is no write-to-read bypass.
REQ-025 The stable counter SHALL be 64 bits, increment by 1 every cycle and wrap from all-ones to 0.

Reset
REQ-026 On reset the outputs and state SHALL be:
- TCFG=0, TVAL=all-ones (TIMESIZE bits), armed=0, timer_int=0, TID=0;
- stable counter=0, so cnt_lo=cnt_hi=0;
- csr_rdata follows the reset state.
REQ-027 Reset during countdown SHALL override any concurrent CSR write.
- No interrupt is set on that edge.

Configuration
REQ-028 Macro STABLE_COUNTER_EN SHALL control the 64-bit stable counter.
- Defined: the counter is built and REQ-025 applies.
- Undefined: no counter flops exist and cnt_lo/cnt_hi are tied to 0.
- All other behaviour is identical in both builds.

Verification
REQ-029 TCFG write 0x0000_0015 (InitVal=5, Periodic=0, En=1) -> TVAL sequence 5,4,3,2,1,0,0xFFF; timer_int=1 from the 1->0 edge; then TVAL holds 0xFFF.
REQ-030 TCFG write 0x0000_000F (InitVal=3, Periodic=1, En=1) -> TVAL sequence 3,2,1,0,3,2,1,0; timer_int rises at the first 1->0 edge.
REQ-031 timer_int=1, then a TICLR write of 0x1 -> timer_int=0 next cycle; a TICLR write coinciding with the expiry edge -> timer_int stays 1.
REQ-032 Mid-count (TVAL=2), TCFG write 0x0000_0029 (InitVal=10) -> TVAL=10 next cycle with no expiry; assert reset mid-count -> TVAL=0xFFF, timer_int=0, TCFG reads 0.
REQ-033 With STABLE_COUNTER_EN defined, 10 cycles after reset release -> cnt_lo=10, cnt_hi=0; without it -> both stay 0.
REQ-034 TID write 0x1234_5678 -> csr_raddr=0x040 reads 0x1234_5678 next cycle; csr_raddr=0x044 -> reads 0.
